// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory port.
// Data wins in IDLE unless a waiting fetch has seen STARVE_MAX consecutive data grants.
module mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_flush_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic              m_ready_i,
    input  logic [DATA_W-1:0] m_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] starve_cnt_r;
    logic       starve_ok_s;
    logic       kill_r;
    logic       kill_s;
    logic       d_gnt_s;
    logic       i_gnt_s;

    // Arbitration and next-state selection; grants exist only in IDLE
    always_comb begin
        state_nxt_s = state_r;
        d_gnt_s     = 1'b0;
        i_gnt_s     = 1'b0;
        starve_ok_s = (starve_cnt_r < STARVE_LIM);
        kill_s      = kill_r | i_flush_i;
        case (state_r)
            IDLE: begin
                if (d_req_i && (!i_req_i || i_flush_i || starve_ok_s)) begin
                    d_gnt_s     = 1'b1;
                    state_nxt_s = BUSY_D;
                end else if (i_req_i && !i_flush_i) begin
                    i_gnt_s     = 1'b1;
                    state_nxt_s = BUSY_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I: begin
                if (m_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY_I;
                end
            end
            BUSY_D: begin
                if (m_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY_D;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Grants are combinational but must read low while reset is held
    assign i_gnt_o = i_gnt_s & rst_n;
    assign d_gnt_o = d_gnt_s & rst_n;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Consecutive data grants while a fetch waits, saturating at STARVE_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 4'd0;
        end else if (d_gnt_s) begin
            if (!i_req_i) begin
                starve_cnt_r <= 4'd0;
            end else if (starve_ok_s) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else if (i_gnt_s) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // A redirect during an outstanding fetch marks its response as dead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_r <= 1'b0;
        end else if (state_r == BUSY_I && !m_ready_i) begin
            kill_r <= kill_s;
        end else begin
            kill_r <= 1'b0;
        end
    end

    // Memory request side: capture on grant, hold until m_ready_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_addr_o  <= {ADDR_W{1'b0}};
            m_wdata_o <= {DATA_W{1'b0}};
        end else if (d_gnt_s) begin
            m_req_o   <= 1'b1;
            m_we_o    <= d_we_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
        end else if (i_gnt_s) begin
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_addr_o  <= i_addr_i;
            m_wdata_o <= {DATA_W{1'b0}};
        end else if (state_r != IDLE && m_ready_i) begin
            m_req_o   <= 1'b0;
        end
    end

    // Response side: one-cycle rvalid pulses, read data held between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid_o <= 1'b0;
            d_rvalid_o <= 1'b0;
            i_rdata_o  <= {DATA_W{1'b0}};
            d_rdata_o  <= {DATA_W{1'b0}};
        end else begin
            i_rvalid_o <= 1'b0;
            d_rvalid_o <= 1'b0;
            case (state_r)
                BUSY_I: begin
                    if (m_ready_i && !kill_s) begin
                        i_rvalid_o <= 1'b1;
                        i_rdata_o  <= m_rdata_i;
                    end
                end
                BUSY_D: begin
                    if (m_ready_i) begin
                        d_rvalid_o <= 1'b1;
                        d_rdata_o  <= m_we_o ? {DATA_W{1'b0}} : m_rdata_i;
                    end
                end
                default: begin
                    i_rvalid_o <= 1'b0;
                    d_rvalid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: arbitration table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req_i = 1'b0, i_flush_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0, m_ready_i = 1'b0;
    logic [AW-1:0] i_addr_i = '0, d_addr_i = '0;
    logic [DW-1:0] d_wdata_i = '0, m_rdata_i = '0;
    logic          i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o, m_req_o, m_we_o;
    logic [DW-1:0] i_rdata_o, d_rdata_o, m_wdata_o;
    logic [AW-1:0] m_addr_o;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
        .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_ready_i(m_ready_i), .m_rdata_i(m_rdata_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which transaction (if any) is in flight and what the
    // requester should see next cycle.
    int          busy;     // 0 none, 1 fetch, 2 data
    logic [31:0] c_addr, c_wdata;
    bit          c_we, killed;
    int          starve;
    bit          e_iv, e_dv;
    logic [31:0] e_ird, e_drd;

    // Values seen at the last sample point, for directed checks
    bit          o_ig, o_dg, o_iv, o_dv, o_mreq, o_mwe;
    logic [31:0] o_addr, o_wdata, o_ird, o_drd;

    task automatic model_reset();
        busy = 0; killed = 0; starve = 0;
        e_iv = 0; e_dv = 0; e_ird = '0; e_drd = '0;
        c_addr = '0; c_we = 0; c_wdata = '0;
    endtask

    // Drive one cycle (called at posedge+1), check at negedge, advance model
    task automatic step(input bit ir, input logic [31:0] ia, input bit fl,
                        input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dwd,
                        input bit rdy, input logic [31:0] rd);
        bit dg, ig;
        i_req_i = ir; i_addr_i = ia; i_flush_i = fl;
        d_req_i = dr; d_we_i = dw; d_addr_i = da; d_wdata_i = dwd;
        m_ready_i = rdy; m_rdata_i = rd;
        @(negedge clk);
        dg = (busy == 0) && dr && (!ir || fl || starve < SM);
        ig = (busy == 0) && !dg && ir && !fl;
        o_ig = i_gnt_o; o_dg = d_gnt_o; o_iv = i_rvalid_o; o_dv = d_rvalid_o;
        o_mreq = m_req_o; o_mwe = m_we_o; o_addr = m_addr_o; o_wdata = m_wdata_o;
        o_ird = i_rdata_o; o_drd = d_rdata_o;
        chk("i_gnt", {31'd0, i_gnt_o}, {31'd0, ig});
        chk("d_gnt", {31'd0, d_gnt_o}, {31'd0, dg});
        chk("m_req", {31'd0, m_req_o}, {31'd0, busy != 0});
        if (busy != 0) begin
            chk("m_addr", m_addr_o, c_addr);
            chk("m_we", {31'd0, m_we_o}, {31'd0, c_we});
            chk("m_wdata", m_wdata_o, c_wdata);
        end
        chk("i_rvalid", {31'd0, i_rvalid_o}, {31'd0, e_iv});
        chk("d_rvalid", {31'd0, d_rvalid_o}, {31'd0, e_dv});
        chk("i_rdata", i_rdata_o, e_ird);
        chk("d_rdata", d_rdata_o, e_drd);
        e_iv = 0; e_dv = 0;
        if (busy != 0) begin
            if (busy == 1 && fl) killed = 1;
            if (rdy) begin
                if (busy == 1 && !killed) begin e_iv = 1; e_ird = rd; end
                if (busy == 2) begin e_dv = 1; e_drd = c_we ? 32'd0 : rd; end
                busy = 0; killed = 0;
            end
        end else if (dg) begin
            busy = 2; c_addr = da; c_we = dw; c_wdata = dwd;
            starve = ir ? ((starve + 1 > SM) ? SM : starve + 1) : 0;
        end else if (ig) begin
            busy = 1; c_addr = ia; c_we = 0; c_wdata = 32'd0; starve = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input logic [31:0] rd);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rdy, rd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req_i = 1'b0; i_flush_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; m_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit ir, fl, dr;
        bit exp_ig, exp_dg;
    } arb_vec_t;

    arb_vec_t vecs[8];
    int       gseq[$];

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 1, 0};
        vecs[2] = '{1, 1, 0, 0, 0};
        vecs[3] = '{0, 0, 1, 0, 1};
        vecs[4] = '{1, 0, 1, 0, 1};
        vecs[5] = '{1, 1, 1, 0, 1};
        vecs[6] = '{0, 1, 0, 0, 0};
        vecs[7] = '{0, 1, 1, 0, 1};

        // Reset state
        do_reset();
        idle(1'b1, 32'hFFFF_FFFF);
        chk("rst_m_req", {31'd0, o_mreq}, 32'd0);
        chk("rst_m_addr", o_addr, 32'd0);
        chk("rst_i_rdata", o_ird, 32'd0);
        chk("rst_d_rdata", o_drd, 32'd0);

        // Arbitration table from a fresh IDLE with starve_cnt=0
        foreach (vecs[k]) begin
            do_reset();
            step(vecs[k].ir, 32'h40 + 32'(k), vecs[k].fl, vecs[k].dr, 1'b0, 32'h80 + 32'(k), 32'd0, 1'b1, 32'h1);
            chk($sformatf("vec%0d_i_gnt", k), {31'd0, o_ig}, {31'd0, vecs[k].exp_ig});
            chk($sformatf("vec%0d_d_gnt", k), {31'd0, o_dg}, {31'd0, vecs[k].exp_dg});
            idle(1'b1, 32'h1234_0000 + 32'(k));
            idle(1'b1, 32'd0);
        end

        // Single fetch with zero-wait memory
        do_reset();
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0050_0093);
        chk("fetch_gnt", {31'd0, o_ig}, 32'd1);
        idle(1'b1, 32'h0050_0093);
        chk("fetch_m_req", {31'd0, o_mreq}, 32'd1);
        chk("fetch_m_addr", o_addr, 32'h100);
        idle(1'b1, 32'd0);
        chk("fetch_rvalid", {31'd0, o_iv}, 32'd1);
        chk("fetch_rdata", o_ird, 32'h0050_0093);

        // Simultaneous requests: data store wins, ack with zero data
        do_reset();
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
        chk("both_d_gnt", {31'd0, o_dg}, 32'd1);
        chk("both_i_gnt", {31'd0, o_ig}, 32'd0);
        idle(1'b1, 32'h1234_5678);
        chk("store_we", {31'd0, o_mwe}, 32'd1);
        chk("store_addr", o_addr, 32'h200);
        chk("store_wdata", o_wdata, 32'hDEAD_BEEF);
        idle(1'b0, 32'd0);
        chk("store_rvalid", {31'd0, o_dv}, 32'd1);
        chk("store_rdata", o_drd, 32'd0);

        // Starvation: both held, grant order D D D D I D D D D I
        do_reset();
        gseq.delete();
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h600, 32'd0, 1'b1, 32'(c));
            if (o_dg) gseq.push_back(2);
            else if (o_ig) gseq.push_back(1);
        end
        chk("starve_ngrants", 32'(gseq.size()), 32'd10);
        for (int g = 0; g < 10 && g < gseq.size(); g++)
            chk($sformatf("starve_grant%0d", g), 32'(gseq[g]), (g == 4 || g == 9) ? 32'd1 : 32'd2);

        // Flush during a waiting fetch: access completes, response dropped
        do_reset();
        step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
        chk("flush_m_req_held", {31'd0, o_mreq}, 32'd1);
        idle(1'b1, 32'hBAD0_BAD0);
        chk("flush_m_addr", o_addr, 32'h700);
        step(1'b1, 32'h704, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
        chk("flush_no_rvalid", {31'd0, o_iv}, 32'd0);
        chk("flush_regrant", {31'd0, o_ig}, 32'd1);
        idle(1'b1, 32'h1111_2222);
        idle(1'b0, 32'd0);
        chk("flush_next_rvalid", {31'd0, o_iv}, 32'd1);
        chk("flush_next_rdata", o_ird, 32'h1111_2222);

        // Five wait states on a data load
        do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h800, 32'd0, 1'b0, 32'd0);
        for (int w = 0; w < 5; w++) begin
            step(1'b1, 32'h900, 1'b0, 1'b1, 1'b0, 32'hA00, 32'd0, 1'b0, 32'd0);
            chk("wait_no_gnt", {31'd0, o_ig | o_dg}, 32'd0);
            chk("wait_m_addr", o_addr, 32'h800);
        end
        idle(1'b1, 32'hCAFE_F00D);
        idle(1'b0, 32'd0);
        chk("wait_rvalid", {31'd0, o_dv}, 32'd1);
        chk("wait_rdata", o_drd, 32'hCAFE_F00D);

        // Reset dropped while a data access is outstanding
        do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hB00, 32'd0, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
        i_req_i = 1'b1; d_req_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_req", {31'd0, m_req_o}, 32'd0);
        chk("midrst_d_gnt", {31'd0, d_gnt_o}, 32'd0);
        chk("midrst_i_gnt", {31'd0, i_gnt_o}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hC00, 32'd0, 1'b1, 32'h5555_AAAA);
        chk("postrst_d_gnt", {31'd0, o_dg}, 32'd1);
        chk("postrst_no_rvalid", {31'd0, o_dv}, 32'd0);
        idle(1'b1, 32'h5555_AAAA);
        idle(1'b0, 32'd0);

        // Random traffic against the reference model
        do_reset();
        for (int r = 0; r < 600; r++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
                 $urandom_range(0, 4) > 1, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
